draw_scheduler: RTL and testbench
=================================

DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100000, grant watchdog limit in clk cycles (used only with DRAW_SCHED_TIMEOUT_EN).
REQ-002 clk  in  1  system clock; all state on rising edge.
REQ-003 resetn  in  1  reset, synchronous, active-low.
REQ-004 scr_req  in  1  full-screen draw request (level).
REQ-005 scr_sel  in  2  screen code: 0 clear, 1 start, 2 game-over, 3 winner.
REQ-006 scr_draw  out  4  one-hot strobes to screen drawer, bit order {winner, gameover, start, clear}.
REQ-007 scr_x, scr_y  in  9 each; scr_colour  in  3; scr_done  in  1  screen drawer pixel stream and completion.
REQ-008 maze_req, maze_done  in  1 each; maze_x, maze_y  in  9 each; maze_colour  in  3  maze tile drawer.
REQ-009 plr_req, plr_done  in  1 each; plr_x, plr_y  in  9 each; plr_colour  in  3  player sprite drawer.
REQ-010 vga_x, vga_y  out  9 each; vga_colour  out  3; vga_plot  out  1  VGA adapter write port.
REQ-011 grant  out  3  one-hot {plr, maze, scr}; busy  out  1  high when not IDLE; timeout_err  out  1  one-cycle pulse.

Function
REQ-012 States IDLE, GRANT, RELEASE; IDLE->GRANT when any request high; GRANT->RELEASE on granted requester's done (or timeout); RELEASE->IDLE unconditionally after one cycle.
REQ-013 Priority: scr_req beats maze/player; between maze_req and plr_req, two-way round-robin, last-served loses a tie; pointer resets to favour maze.
REQ-014 Grant latency: request sampled in IDLE -> grant asserted on next clock edge; grant stays constant throughout GRANT.
REQ-015 scr_sel latched into a register when scr granted; scr_draw equals decode of latched code while GRANT and scr granted, else 0; later scr_sel changes ignored.
REQ-016 vga_x/vga_y/vga_colour registered from granted source each cycle in GRANT (one-cycle latency); vga_plot registered = GRANT and granted done low.
REQ-017 Outside GRANT: vga_x, vga_y, vga_colour, vga_plot all 0.
REQ-018 Granted requester dropping req mid-GRANT ignored; grant held until its done.
REQ-019 done from non-granted requesters ignored in all states.
REQ-020 RELEASE drops all strobes for one cycle so the screen drawer clears its done before any new grant; requests present in RELEASE are served from IDLE next cycle.
REQ-021 Simultaneous done and new request in same cycle: done wins, new request arbitrated only after RELEASE.
REQ-022 Round-robin pointer updated only on grant of maze or player, not on scr.

Reset
REQ-023 resetn low at clock edge: state IDLE, grant 0, scr_draw 0, latched sel 0, vga_* 0, busy 0, timeout_err 0, RR pointer maze, watchdog 0; applies mid-GRANT with no RELEASE cycle.

Configuration
REQ-024 Macro DRAW_SCHED_TIMEOUT_EN defined: watchdog counts GRANT cycles from 0; at TIMEOUT_CYCLES-1 without done, force RELEASE and pulse timeout_err one cycle; counter clears on entering GRANT.
REQ-025 Macro undefined: no watchdog logic, timeout_err tied 0, GRANT waits indefinitely for done.

Structure
REQ-026 Shared package draw_sched_pkg holds state enum, grant index constants (SCR, MAZE, PLR), screen codes (CLEAR, START, GAMEOVER, WINNER), coordinate/colour width constants (9, 3).
REQ-027 One sub-module rr_arb2: two-requester round-robin with pointer register and update enable.

Verification
REQ-028 scr_req=1, scr_sel=3 from IDLE -> grant=001 next cycle, scr_draw=1000; scr_x=80,scr_y=5,colour=6 -> vga same values one cycle later with vga_plot=1.
REQ-029 scr_req, maze_req, plr_req all high -> scr first; after scr_done, RELEASE (vga_plot=0, grant=000) one cycle, then maze, then plr, then maze.
REQ-030 scr granted, scr_sel changed 2->0 mid-draw -> scr_draw stays 0100 until scr_done.
REQ-031 resetn low during maze GRANT -> next cycle grant=000, vga_plot=0, busy=0, no RELEASE cycle.
REQ-032 TIMEOUT_EN, TIMEOUT_CYCLES=16, maze granted, maze_done never -> timeout_err pulses on 16th GRANT cycle, RELEASE follows; without macro grant held past 1000 cycles.
REQ-033 plr_done pulse while maze granted -> ignored, maze grant held until maze_done.

Source files
------------

// File: rtl/draw_sched_pkg.sv
// Shared constants for the draw scheduler: FSM states, grant indices, screen codes and
// pixel-bus widths.
package draw_sched_pkg;

  localparam int unsigned CoordW  = 9;
  localparam int unsigned ColourW = 3;

  // Legacy-compatible state encoding.
  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StGrant   = 2'd1;
  localparam logic [1:0] StRelease = 2'd2;

  // Bit positions within the one-hot grant vector.
  localparam int unsigned SCR  = 0;
  localparam int unsigned MAZE = 1;
  localparam int unsigned PLR  = 2;

  typedef enum logic [1:0] {
    CLEAR    = 2'd0,
    START    = 2'd1,
    GAMEOVER = 2'd2,
    WINNER   = 2'd3
  } scr_code_e;

  // One-hot strobe for the screen drawer, bit order {winner, gameover, start, clear}.
  function automatic logic [3:0] scr_decode(input logic [1:0] code);
    scr_decode = 4'b0001 << code;
  endfunction

endpackage

// File: rtl/draw_scheduler_rr_arb2.sv
// Two-requester round-robin arbiter; the requester served last loses a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  // ptr_q == 0 favours req[0] on a tie.
  logic ptr_q, ptr_d;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr_q ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (update && (gnt != 2'b00)) begin
      ptr_d = gnt[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// Arbitrates the screen, maze and player drawers onto a single VGA write port.
// Optional grant watchdog enabled by defining DRAW_SCHED_TIMEOUT_EN.
module draw_scheduler
  import draw_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               scr_req,
  input  logic [1:0]         scr_sel,
  output logic [3:0]         scr_draw,
  input  logic [CoordW-1:0]  scr_x,
  input  logic [CoordW-1:0]  scr_y,
  input  logic [ColourW-1:0] scr_colour,
  input  logic               scr_done,
  input  logic               maze_req,
  input  logic               maze_done,
  input  logic [CoordW-1:0]  maze_x,
  input  logic [CoordW-1:0]  maze_y,
  input  logic [ColourW-1:0] maze_colour,
  input  logic               plr_req,
  input  logic               plr_done,
  input  logic [CoordW-1:0]  plr_x,
  input  logic [CoordW-1:0]  plr_y,
  input  logic [ColourW-1:0] plr_colour,
  output logic [CoordW-1:0]  vga_x,
  output logic [CoordW-1:0]  vga_y,
  output logic [ColourW-1:0] vga_colour,
  output logic               vga_plot,
  output logic [2:0]         grant,
  output logic               busy,
  output logic               timeout_err
);

  logic [1:0]         state_q, state_d;
  logic [2:0]         grant_q, grant_d;
  logic [1:0]         sel_q, sel_d;
  logic [CoordW-1:0]  vx_q, vx_d, vy_q, vy_d;
  logic [ColourW-1:0] vc_q, vc_d;
  logic               plot_q, plot_d;

  logic [1:0] arb_gnt;
  logic       arb_update;
  logic       granted_done;
  logic       timeout;

  // Only the granted requester's done counts; others are masked out.
  assign granted_done = |(grant_q & {plr_done, maze_done, scr_done});

  // The pointer moves only when maze or player actually wins from IDLE.
  assign arb_update = (state_q == StIdle) && !scr_req && (maze_req || plr_req);

  rr_arb2 u_arb (
    .clk    (clk),
    .resetn (resetn),
    .req    ({plr_req, maze_req}),
    .update (arb_update),
    .gnt    (arb_gnt)
  );

`ifdef DRAW_SCHED_TIMEOUT_EN
  localparam int unsigned WdW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [WdW-1:0] wd_q, wd_d;

  assign timeout = (state_q == StGrant) && !granted_done &&
                   (wd_q == WdW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_d = '0;
    if (state_q == StGrant) begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign timeout_err = timeout;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    case (state_q)
      StIdle: begin
        if (scr_req) begin
          grant_d      = '0;
          grant_d[SCR] = 1'b1;
          sel_d        = scr_sel;
          state_d      = StGrant;
        end else if (arb_gnt != 2'b00) begin
          grant_d       = '0;
          grant_d[MAZE] = arb_gnt[0];
          grant_d[PLR]  = arb_gnt[1];
          state_d       = StGrant;
        end
      end
      StGrant: begin
        if (granted_done || timeout) begin
          grant_d = '0;
          state_d = StRelease;
        end
      end
      StRelease: begin
        state_d = StIdle;
      end
      default: begin
        grant_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Pixel port is loaded only while the grant persists, so it reads zero in IDLE/RELEASE.
  always_comb begin
    vx_d   = '0;
    vy_d   = '0;
    vc_d   = '0;
    plot_d = 1'b0;
    if ((state_q == StGrant) && (state_d == StGrant)) begin
      plot_d = 1'b1;
      unique case (1'b1)
        grant_q[SCR]: begin
          vx_d = scr_x;
          vy_d = scr_y;
          vc_d = scr_colour;
        end
        grant_q[MAZE]: begin
          vx_d = maze_x;
          vy_d = maze_y;
          vc_d = maze_colour;
        end
        grant_q[PLR]: begin
          vx_d = plr_x;
          vy_d = plr_y;
          vc_d = plr_colour;
        end
        default: begin
          plot_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      grant_q <= '0;
      sel_q   <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
      vc_q    <= '0;
      plot_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      vc_q    <= vc_d;
      plot_q  <= plot_d;
    end
  end

  assign grant      = grant_q;
  assign busy       = (state_q != StIdle);
  assign scr_draw   = ((state_q == StGrant) && grant_q[SCR]) ? scr_decode(sel_q) : 4'b0000;
  assign vga_x      = vx_q;
  assign vga_y      = vy_q;
  assign vga_colour = vc_q;
  assign vga_plot   = plot_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed and randomized checks of draw_scheduler against a transaction-level model.
module tb_draw_scheduler;

  logic       clk = 1'b0;
  logic       resetn;
  logic       scr_req, scr_done, maze_req, maze_done, plr_req, plr_done;
  logic [1:0] scr_sel;
  logic [3:0] scr_draw;
  logic [8:0] scr_x, scr_y, maze_x, maze_y, plr_x, plr_y, vga_x, vga_y;
  logic [2:0] scr_colour, maze_colour, plr_colour, vga_colour, grant;
  logic       vga_plot, busy, timeout_err;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  draw_scheduler #(.TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .scr_req     (scr_req),
    .scr_sel     (scr_sel),
    .scr_draw    (scr_draw),
    .scr_x       (scr_x),
    .scr_y       (scr_y),
    .scr_colour  (scr_colour),
    .scr_done    (scr_done),
    .maze_req    (maze_req),
    .maze_done   (maze_done),
    .maze_x      (maze_x),
    .maze_y      (maze_y),
    .maze_colour (maze_colour),
    .plr_req     (plr_req),
    .plr_done    (plr_done),
    .plr_x       (plr_x),
    .plr_y       (plr_y),
    .plr_colour  (plr_colour),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_colour  (vga_colour),
    .vga_plot    (vga_plot),
    .grant       (grant),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    scr_req = 0; scr_sel = 0; scr_done = 0; scr_x = 0; scr_y = 0; scr_colour = 0;
    maze_req = 0; maze_done = 0; maze_x = 0; maze_y = 0; maze_colour = 0;
    plr_req = 0; plr_done = 0; plr_x = 0; plr_y = 0; plr_colour = 0;
  endtask

  task automatic do_reset();
    resetn = 0;
    tick();
    tick();
    resetn = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL global time limit reached");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    logic       favour_plr;
    logic [2:0] exp_g;
    logic [1:0] sel;
    logic [8:0] ex, ey;
    logic [2:0] ec, rq, dn;
    logic [3:0] exp_draw;
    logic       saw_to;
    int         len;

    clear_inputs();
    do_reset();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_draw", 32'(scr_draw), 32'd0);
    check("rst_plot", 32'(vga_plot), 32'd0);
    check("rst_vga_x", 32'(vga_x), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);

    // Screen grant and one-cycle pixel latency.
    scr_req = 1; scr_sel = 3;
    tick();
    check("s1_grant", 32'(grant), 32'b001);
    check("s1_draw", 32'(scr_draw), 32'b1000);
    check("s1_busy", 32'(busy), 32'd1);
    check("s1_plot0", 32'(vga_plot), 32'd0);
    scr_req = 0; scr_x = 80; scr_y = 5; scr_colour = 6;
    tick();
    check("s1_vx", 32'(vga_x), 32'd80);
    check("s1_vy", 32'(vga_y), 32'd5);
    check("s1_vc", 32'(vga_colour), 32'd6);
    check("s1_plot", 32'(vga_plot), 32'd1);
    scr_done = 1;
    tick();
    check("s1_rel_grant", 32'(grant), 32'd0);
    check("s1_rel_plot", 32'(vga_plot), 32'd0);
    check("s1_rel_vx", 32'(vga_x), 32'd0);
    check("s1_rel_busy", 32'(busy), 32'd1);
    scr_done = 0;
    tick();
    check("s1_idle_busy", 32'(busy), 32'd0);

    // Latched screen code ignores later scr_sel changes.
    scr_req = 1; scr_sel = 2;
    tick();
    check("sel_draw0", 32'(scr_draw), 32'b0100);
    scr_req = 0; scr_sel = 0;
    tick();
    check("sel_draw1", 32'(scr_draw), 32'b0100);
    tick();
    check("sel_draw2", 32'(scr_draw), 32'b0100);
    scr_done = 1;
    tick();
    check("sel_draw_rel", 32'(scr_draw), 32'd0);
    scr_done = 0;
    tick();

    // All three request: scr, then maze/plr alternate, each separated by RELEASE.
    scr_req = 1; maze_req = 1; plr_req = 1; scr_sel = 1;
    tick();
    check("pri_scr", 32'(grant), 32'b001);
    scr_done = 1;
    tick();
    check("pri_rel_grant", 32'(grant), 32'd0);
    check("pri_rel_plot", 32'(vga_plot), 32'd0);
    scr_done = 0; scr_req = 0;
    tick();
    check("pri_idle_busy", 32'(busy), 32'd0);
    tick();
    check("pri_maze", 32'(grant), 32'b010);
    maze_done = 1;
    tick();
    check("pri_rel2", 32'(grant), 32'd0);
    maze_done = 0;
    tick();
    tick();
    check("pri_plr", 32'(grant), 32'b100);
    plr_done = 1;
    tick();
    plr_done = 0;
    tick();
    tick();
    check("pri_maze2", 32'(grant), 32'b010);

    // Foreign done and dropped request leave the maze grant alone.
    plr_done = 1;
    tick();
    check("fdone_grant", 32'(grant), 32'b010);
    plr_done = 0; maze_req = 0; plr_req = 0;
    tick();
    check("drop_grant", 32'(grant), 32'b010);

    // Reset in the middle of a grant goes straight to IDLE.
    resetn = 0;
    tick();
    check("mrst_grant", 32'(grant), 32'd0);
    check("mrst_plot", 32'(vga_plot), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    resetn = 1;
    tick();
    check("mrst_norel", 32'(busy), 32'd0);

    // Grant watchdog.
    maze_req = 1;
    tick();
    maze_req = 0;
    check("wd_grant", 32'(grant), 32'b010);
`ifdef DRAW_SCHED_TIMEOUT_EN
    for (int c = 1; c < 16; c++) begin
      check("wd_no_pulse", 32'(timeout_err), 32'd0);
      tick();
    end
    check("wd_pulse", 32'(timeout_err), 32'd1);
    tick();
    check("wd_rel_grant", 32'(grant), 32'd0);
    check("wd_rel_busy", 32'(busy), 32'd1);
    check("wd_pulse_end", 32'(timeout_err), 32'd0);
    tick();
`else
    saw_to = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (timeout_err === 1'b1) saw_to = 1'b1;
    end
    check("wd_held", 32'(grant), 32'b010);
    check("wd_never", 32'(saw_to), 32'd0);
    maze_done = 1;
    tick();
    check("wd_done_rel", 32'(grant), 32'd0);
    maze_done = 0;
    tick();
`endif

    // Randomized transactions against a transaction-level model.
    clear_inputs();
    do_reset();
    favour_plr = 1'b0;
    for (int t = 0; t < 40; t++) begin
      rq  = 3'($urandom_range(1, 7));
      sel = 2'($urandom);
      if (rq[0]) exp_g = 3'b001;
      else if (rq[1] && rq[2]) exp_g = favour_plr ? 3'b100 : 3'b010;
      else exp_g = rq[1] ? 3'b010 : 3'b100;
      if (exp_g == 3'b010) favour_plr = 1'b1;
      if (exp_g == 3'b100) favour_plr = 1'b0;
      exp_draw = (exp_g == 3'b001) ? (4'b0001 << sel) : 4'b0000;

      scr_req = rq[0]; maze_req = rq[1]; plr_req = rq[2]; scr_sel = sel;
      tick();
      check("rnd_grant", 32'(grant), 32'(exp_g));
      check("rnd_busy", 32'(busy), 32'd1);
      check("rnd_draw", 32'(scr_draw), 32'(exp_draw));
      check("rnd_plot0", 32'(vga_plot), 32'd0);
      scr_req = 0; maze_req = 0; plr_req = 0;

      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++) begin
        scr_x = 9'($urandom); scr_y = 9'($urandom); scr_colour = 3'($urandom);
        maze_x = 9'($urandom); maze_y = 9'($urandom); maze_colour = 3'($urandom);
        plr_x = 9'($urandom); plr_y = 9'($urandom); plr_colour = 3'($urandom);
        scr_sel = 2'($urandom);
        dn = 3'($urandom) & ~exp_g;
        scr_done = dn[0]; maze_done = dn[1]; plr_done = dn[2];
        if (exp_g == 3'b001) begin ex = scr_x; ey = scr_y; ec = scr_colour; end
        else if (exp_g == 3'b010) begin ex = maze_x; ey = maze_y; ec = maze_colour; end
        else begin ex = plr_x; ey = plr_y; ec = plr_colour; end
        tick();
        check("rnd_vx", 32'(vga_x), 32'(ex));
        check("rnd_vy", 32'(vga_y), 32'(ey));
        check("rnd_vc", 32'(vga_colour), 32'(ec));
        check("rnd_plot", 32'(vga_plot), 32'd1);
        check("rnd_hold", 32'(grant), 32'(exp_g));
        check("rnd_draw_hold", 32'(scr_draw), 32'(exp_draw));
      end

      dn = 3'($urandom) | exp_g;
      scr_done = dn[0]; maze_done = dn[1]; plr_done = dn[2];
      tick();
      check("rnd_rel_grant", 32'(grant), 32'd0);
      check("rnd_rel_plot", 32'(vga_plot), 32'd0);
      check("rnd_rel_vx", 32'(vga_x), 32'd0);
      check("rnd_rel_busy", 32'(busy), 32'd1);
      scr_done = 0; maze_done = 0; plr_done = 0;
      tick();
      check("rnd_idle_busy", 32'(busy), 32'd0);
      check("rnd_idle_grant", 32'(grant), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
